// File: rtl/kamus_pkg.sv
// Shared types and helpers for the kamus core memory stage.
//   operation_e     : 6-bit operation code delivered by EX
//   mem_state_e     : memory stage FSM states (IDLE, REQ, RESP)
//   mem_size_e      : access width of a load/store
//   instr_decoded_t : bundle captured while a memory access is in flight
//   WB_SEL_*        : write-back source select encodings
//   is_load / is_store / mem_size : operation classification helpers
package kamus_pkg;

   typedef enum logic [5:0] {
      OP_NOP   = 6'h00,
      OP_ADD   = 6'h01,
      OP_SUB   = 6'h02,
      OP_AND   = 6'h03,
      OP_OR    = 6'h04,
      OP_XOR   = 6'h05,
      OP_SLL   = 6'h06,
      OP_SRL   = 6'h07,
      OP_SRA   = 6'h08,
      OP_SLT   = 6'h09,
      OP_SLTU  = 6'h0A,
      OP_LUI   = 6'h0B,
      OP_AUIPC = 6'h0C,
      OP_JAL   = 6'h0D,
      OP_JALR  = 6'h0E,
      OP_LB    = 6'h10,
      OP_LBU   = 6'h11,
      OP_LH    = 6'h12,
      OP_LHU   = 6'h13,
      OP_LW    = 6'h14,
      OP_SB    = 6'h18,
      OP_SH    = 6'h19,
      OP_SW    = 6'h1A
   } operation_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_size_e;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC  = 2'd2;
   localparam logic [1:0] WB_SEL_IMM = 2'd3;

   typedef struct packed {
      operation_e  op;
      logic [31:0] ex_result;
      logic [4:0]  rd_addr;
      logic [31:0] next_pc;
      logic        regfile_wr_en;
      logic [1:0]  wb_mux_sel;
   } instr_decoded_t;

   function automatic logic is_load(input operation_e op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic is_store(input operation_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Non-memory operations report word size; callers qualify with is_load/is_store.
   function automatic mem_size_e mem_size(input operation_e op);
      mem_size_e size;
      case (op)
         OP_LB, OP_LBU, OP_SB: size = SIZE_BYTE;
         OP_LH, OP_LHU, OP_SH: size = SIZE_HALF;
         default:              size = SIZE_WORD;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/kamus_mem_stage_if.sv
// L1D request/grant/response bus between the memory stage and the data cache.
//   req/gnt     : request handshake; request fields are stable until gnt
//   we/be/addr/wdata : request fields (addr is word aligned)
//   rvalid/rdata: response, one per granted request (loads and stores)
// master: memory stage side; slave: cache side.
interface kamus_mem_stage_if;
   logic        req;
   logic        gnt;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/kamus_lsu_align.sv
// Combinational load/store lane formatting.
//   op         : operation being formatted
//   addr_lo    : effective address bits [1:0]
//   rs2        : store source data
//   rdata      : raw word returned by the cache
//   be         : byte enables (all ones for loads)
//   wdata      : store data replicated across lanes
//   load_data  : rdata shifted to bit 0 and sign/zero extended
//   misaligned : memory op whose address is not naturally aligned
module kamus_lsu_align
   import kamus_pkg::*;
(
   input  operation_e  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misaligned
);

   mem_size_e   size;
   logic [31:0] shifted;

   assign size    = mem_size(op);
   assign shifted = rdata >> {addr_lo, 3'b000};

   // Each lane picks the store byte it carries: byte ops replicate rs2[7:0],
   // half ops alternate the two low bytes, word ops pass straight through.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata[8*gi +: 8] = (size == SIZE_BYTE) ? rs2[7:0] :
                                (size == SIZE_HALF) ? rs2[8*(gi%2) +: 8] :
                                                      rs2[8*gi +: 8];
   end

   always_comb begin
      be = 4'hF;
      if (is_store(op)) begin
         case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = 4'b0011 << addr_lo;
            default:   be = 4'hF;
         endcase
      end
   end

   always_comb begin
      load_data = shifted;
      case (op)
         OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU:  load_data = {24'h0, shifted[7:0]};
         OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         OP_LHU:  load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      misaligned = 1'b0;
      if (is_load(op) || is_store(op)) begin
         case (size)
            SIZE_WORD: misaligned = (addr_lo != 2'b00);
            SIZE_HALF: misaligned = addr_lo[0];
            default:   misaligned = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/kamus_mem_stage.sv
// Memory stage of the kamus pipeline.
// Accepts the EX bundle, issues at most one outstanding load/store on the L1D
// bus, formats the result and hands a registered bundle to WB.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   ex_valid_i/ex_ready_o: EX handshake; ready only when idle and WB slot free
//   operation_i .. wb_mux_sel_i : EX bundle fields
//   dmem                 : L1D request/grant/response bus (master side)
//   wb_valid_o/wb_ready_i: WB handshake; WB fields hold until consumed
//   wb_data_o .. exc_addr_o : registered WB bundle and exception flags
module kamus_mem_stage
   import kamus_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                ex_valid_i,
   output logic                ex_ready_o,
   input  operation_e          operation_i,
   input  logic [31:0]         ex_result_i,
   input  logic [31:0]         rs2_data_i,
   input  logic [4:0]          rd_addr_i,
   input  logic [31:0]         next_pc_i,
   input  logic                l1d_wr_en_i,
   input  logic                regfile_wr_en_i,
   input  logic [1:0]          wb_mux_sel_i,
   kamus_mem_stage_if.master   dmem,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic [31:0]         wb_data_o,
   output logic [4:0]          rd_addr_o,
   output logic                regfile_wr_en_o,
   output logic [1:0]          wb_mux_sel_o,
   output logic [31:0]         next_pc_o,
   output logic                misaligned_o,
   output logic                bus_err_o,
   output logic [31:0]         exc_addr_o
);

   localparam int CNT_W = $clog2(RESP_TIMEOUT + 2);

   mem_state_e     state_reg, state_next;
   instr_decoded_t bundle_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic        req_reg, we_reg;
   logic [3:0]  be_reg;
   logic [31:0] addr_reg, wdata_reg;

   logic        wb_valid_reg, wr_en_reg, misaligned_reg, bus_err_reg;
   logic [31:0] wb_data_reg, next_pc_reg, exc_addr_reg;
   logic [4:0]  rd_reg;
   logic [1:0]  mux_reg;

   logic        accept, ex_is_mem, timeout_hit, resp_done;
   operation_e  align_op;
   logic [1:0]  align_lo;
   logic [3:0]  align_be;
   logic [31:0] align_wdata, align_load;
   logic        align_misaligned;

   assign ex_ready_o = (state_reg == IDLE) && (!wb_valid_reg || wb_ready_i);
   assign accept     = ex_valid_i && ex_ready_o;
   assign ex_is_mem  = is_load(operation_i) || is_store(operation_i);

   // While idle the aligner formats the incoming store / checks alignment;
   // once an access is in flight it formats the returning load data.
   assign align_op = (state_reg == IDLE) ? operation_i : bundle_reg.op;
   assign align_lo = (state_reg == IDLE) ? ex_result_i[1:0] : bundle_reg.ex_result[1:0];

   kamus_lsu_align u_align (
      .op         (align_op),
      .addr_lo    (align_lo),
      .rs2        (rs2_data_i),
      .rdata      (dmem.rdata),
      .be         (align_be),
      .wdata      (align_wdata),
      .load_data  (align_load),
      .misaligned (align_misaligned)
   );

   // The counter value is the number of completed RESP cycles without a
   // response, so the error fires at the end of the RESP_TIMEOUT-th cycle.
   assign timeout_hit = (RESP_TIMEOUT != 0) && (state_reg == RESP) && !dmem.rvalid &&
                        (cnt_reg == CNT_W'(RESP_TIMEOUT - 1));
   assign resp_done   = (state_reg == RESP) && dmem.rvalid;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept && ex_is_mem && !align_misaligned) state_next = REQ;
         REQ:     if (dmem.gnt) state_next = RESP;
         RESP:    if (resp_done || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bundle_reg     <= '0;
         cnt_reg        <= '0;
         req_reg        <= 1'b0;
         we_reg         <= 1'b0;
         be_reg         <= 4'h0;
         addr_reg       <= 32'h0;
         wdata_reg      <= 32'h0;
         wb_valid_reg   <= 1'b0;
         wb_data_reg    <= 32'h0;
         rd_reg         <= 5'h0;
         wr_en_reg      <= 1'b0;
         mux_reg        <= 2'h0;
         next_pc_reg    <= 32'h0;
         misaligned_reg <= 1'b0;
         bus_err_reg    <= 1'b0;
         exc_addr_reg   <= 32'h0;
      end else begin
         if (wb_valid_reg && wb_ready_i) wb_valid_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (ex_is_mem && !align_misaligned) begin
                     bundle_reg <= '{op: operation_i, ex_result: ex_result_i,
                                     rd_addr: rd_addr_i, next_pc: next_pc_i,
                                     regfile_wr_en: regfile_wr_en_i,
                                     wb_mux_sel: wb_mux_sel_i};
                     req_reg   <= 1'b1;
                     we_reg    <= is_store(operation_i);
                     be_reg    <= align_be;
                     addr_reg  <= {ex_result_i[31:2], 2'b00};
                     wdata_reg <= align_wdata;
                  end else begin
                     // Non-memory op or misaligned access completes in one cycle.
                     wb_valid_reg   <= 1'b1;
                     wb_data_reg    <= ex_result_i;
                     rd_reg         <= rd_addr_i;
                     wr_en_reg      <= regfile_wr_en_i && !ex_is_mem;
                     mux_reg        <= wb_mux_sel_i;
                     next_pc_reg    <= next_pc_i;
                     misaligned_reg <= ex_is_mem;
                     bus_err_reg    <= 1'b0;
                     exc_addr_reg   <= ex_is_mem ? ex_result_i : 32'h0;
                  end
               end
            end
            REQ: begin
               if (dmem.gnt) begin
                  req_reg <= 1'b0;
                  cnt_reg <= '0;
               end
            end
            RESP: begin
               if (resp_done || timeout_hit) begin
                  wb_valid_reg   <= 1'b1;
                  rd_reg         <= bundle_reg.rd_addr;
                  mux_reg        <= bundle_reg.wb_mux_sel;
                  next_pc_reg    <= bundle_reg.next_pc;
                  misaligned_reg <= 1'b0;
                  cnt_reg        <= '0;
                  if (resp_done) begin
                     wb_data_reg  <= is_store(bundle_reg.op) ? bundle_reg.ex_result : align_load;
                     wr_en_reg    <= bundle_reg.regfile_wr_en && !is_store(bundle_reg.op);
                     bus_err_reg  <= 1'b0;
                     exc_addr_reg <= 32'h0;
                  end else begin
                     wb_data_reg  <= bundle_reg.ex_result;
                     wr_en_reg    <= 1'b0;
                     bus_err_reg  <= 1'b1;
                     exc_addr_reg <= bundle_reg.ex_result;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem.req   = req_reg;
   assign dmem.we    = we_reg;
   assign dmem.be    = be_reg;
   assign dmem.addr  = addr_reg;
   assign dmem.wdata = wdata_reg;

   assign wb_valid_o      = wb_valid_reg;
   assign wb_data_o       = wb_data_reg;
   assign rd_addr_o       = rd_reg;
   assign regfile_wr_en_o = wr_en_reg;
   assign wb_mux_sel_o    = mux_reg;
   assign next_pc_o       = next_pc_reg;
   assign misaligned_o    = misaligned_reg;
   assign bus_err_o       = bus_err_reg;
   assign exc_addr_o      = exc_addr_reg;

   // Decode's store indication must agree with the operation code.
   a_store_flag: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ex_valid_i |-> (l1d_wr_en_i == is_store(operation_i)));

endmodule

// File: doc/kamus_mem_stage.md
Name: kamus_mem_stage

Overview:
- Memory stage of the kamus core pipeline. It consumes the EX-stage result bundle and issues the single outstanding load or store on the L1D request/grant/response interface.
- Formats load data (sign/zero extension) and store lanes (byte enables, replicated data).
- Presents a registered, valid/ready-handshaked bundle to WB.
- Back-pressures EX while a memory access is in flight.

Parameters:
RESP_TIMEOUT, 16, cycles allowed in RESP before a bus error is raised; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
ex_valid_i  in  1  EX bundle valid
ex_ready_o  out  1  MEM accepts the EX bundle this cycle
operation_i  in  6  operation_e from EX
ex_result_i  in  32  ALU result / effective address
rs2_data_i  in  32  store data
rd_addr_i  in  5  destination register
next_pc_i  in  32  pc+4
l1d_wr_en_i  in  1  store indication from decode
regfile_wr_en_i  in  1  rd write enable
wb_mux_sel_i  in  2  WB source select
dmem_req_o  out  1  memory request
dmem_gnt_i  in  1  request granted
dmem_we_o  out  1  write
dmem_be_o  out  4  byte enables
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata_o  out  32  lane-replicated store data
dmem_rvalid_i  in  1  response valid (loads and stores)
dmem_rdata_i  in  32  response data
wb_valid_o  out  1  WB bundle valid
wb_ready_i  in  1  WB accepts
wb_data_o  out  32  formatted load data, else ex_result
rd_addr_o  out  5  registered rd
regfile_wr_en_o  out  1  registered write enable; forced 0 on exception
wb_mux_sel_o  out  2  registered
next_pc_o  out  32  registered
misaligned_o  out  1  exception flag, qualified by wb_valid_o
bus_err_o  out  1  timeout flag, qualified by wb_valid_o
exc_addr_o  out  32  faulting effective address

Behaviour:
- Reset: all outputs 0, FSM IDLE, timeout counter 0. An assertion mid-access abandons it; responses arriving after deassertion and while in IDLE are ignored.
- FSM states: IDLE, REQ, RESP.
- ex_ready_o = (state==IDLE) && (!wb_valid_o || wb_ready_i).
- Accept = ex_valid_i && ex_ready_o.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. Every other op is a non-memory op.
- Non-memory op accepted: next cycle wb_valid_o=1, wb_data_o=ex_result_i, other fields registered. Latency 1.
- Misaligned memory op accepted (W with addr[1:0]!=0; H with addr[0]!=0): no request issued. Next cycle: wb_valid_o=1, misaligned_o=1, exc_addr_o=addr, regfile_wr_en_o=0.
- Aligned memory op accepted:
  - Capture the bundle, go to REQ.
  - dmem_req_o is registered high from the next cycle, with addr/we/be/wdata held stable until dmem_gnt_i.
  - wb_valid_o clears when consumed by wb_ready_i.
- REQ: on dmem_gnt_i, req drops next cycle and the FSM goes to RESP; the counter clears.
- RESP: on dmem_rvalid_i, the bundle is registered to WB (wb_valid_o=1 next cycle) and the FSM returns to IDLE.
  - Loads: wb_data_o = rdata >> (8*addr[1:0]), then LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged.
  - Stores: wb_data_o = ex_result, regfile_wr_en_o = 0.
- RESP timeout: the counter increments each cycle without rvalid. When it reaches RESP_TIMEOUT (nonzero): wb_valid_o=1, bus_err_o=1, exc_addr_o=addr, regfile_wr_en_o=0, FSM to IDLE.
- Minimum load latency: accept T, req+gnt T+1, rvalid T+2, wb_valid_o T+3.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 4'hF, wdata = rs2.
  - Loads: be = 4'hF, we = 0.
- WB hold: wb_valid_o and all wb fields are held stable until wb_ready_i. Nothing is ever dropped or overwritten.
- Simultaneous consume and accept: wb_ready_i while a non-memory op is accepted loads the new bundle with no bubble.
- l1d_wr_en_i must equal "op is store"; a mismatch is an assertion failure, and dmem_we_o is derived from operation_i.
- gnt or rvalid outside REQ/RESP is ignored.

Decomposition:
- kamus_pkg holds: operation_e, instr_decoded_t, mem_state_e {IDLE,REQ,RESP}, the is_load/is_store/mem_size helper functions, and WB_SEL_* constants.
- One sub-module, kamus_lsu_align: combinational store lane/byte-enable generation, load extraction/extension, and misalignment detection.
- FSM, pipeline register and timeout counter stay in kamus_mem_stage.

Test Plan:
- ADD with ex_result=0x1234, wb_ready_i=1 → wb_valid_o next cycle, wb_data_o=0x1234, regfile_wr_en_o=1.
- LB addr=0x103, gnt immediate, rdata=0x80FF_0000 → dmem_addr_o=0x100, be=4'hF, wb_data_o=0xFFFF_FF80 at T+3; LBU same → 0x0000_0080.
- SH addr=0x202, rs2=0xABCD_1234, gnt delayed 3 cycles → req/addr/be held stable; be=4'b1100, wdata=0x1234_1234, regfile_wr_en_o=0.
- LW addr=0x301 → no dmem_req_o; misaligned_o=1, exc_addr_o=0x301, regfile_wr_en_o=0.
- LW granted, rvalid never arrives, RESP_TIMEOUT=16 → bus_err_o=1 after 16 RESP cycles, FSM IDLE; a late rvalid is ignored.
- Back-to-back ADDs with wb_ready_i low for 2 cycles → ex_ready_o=0, outputs stable, no loss. rst_ni pulsed during RESP → outputs 0, subsequent rvalid ignored.
